// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among N_REQ producers
module fifo_push_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         gnt,
    input  logic                     fifo_full,
    output logic                     fifo_push,
    output logic [DW-1:0]            fifo_data_in,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr, rr_next;
    logic [IW-1:0]   owner_next;
    logic [CW-1:0]   burst_cnt, cnt_next;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;

    // Index after i, wrapping from N_REQ-1 back to 0 (N_REQ need not be a power of two)
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(N_REQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Round-robin search: first requester at or after rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

    // State register: FSM state, priority pointer, burst owner and burst length
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_next;
            owner     <= owner_next;
            burst_cnt <= cnt_next;
        end
    end

    // Next-state: start bursts on an IDLE grant, end them on length limit or owner release
    always_comb begin
        state_next = state;
        rr_next    = rr_ptr;
        owner_next = owner;
        cnt_next   = burst_cnt;
        case (state)
            IDLE: begin
                if (fifo_push) begin
                    owner_next = sel_idx;
                    if (MAX_BURST == 1) begin
                        rr_next = next_idx(sel_idx);
                    end else begin
                        state_next = BURST;
                        cnt_next   = CW'(1);
                    end
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    // Owner released early: hand priority on, one bubble cycle
                    state_next = IDLE;
                    rr_next    = next_idx(owner);
                end else if (fifo_push) begin
                    cnt_next = burst_cnt + 1'b1;
                    if (burst_cnt == CW'(MAX_BURST - 1)) begin
                        state_next = IDLE;
                        rr_next    = next_idx(owner);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: zero-latency grant, push strobe and write-data mux
    always_comb begin
        gnt          = '0;
        fifo_data_in = '0;
        if (!rst && !fifo_full) begin
            case (state)
                IDLE:    if (sel_found) gnt[sel_idx] = 1'b1;
                BURST:   if (req[owner]) gnt[owner] = 1'b1;
                default: gnt = '0;
            endcase
        end
        for (int i = 0; i < N_REQ; i++) begin
            fifo_data_in = fifo_data_in | ({DW{gnt[i]}} & req_data[i*DW +: DW]);
        end
        fifo_push = |gnt;
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  gnt;
    logic          fifo_full;
    logic          fifo_push;
    logic [DW-1:0] fifo_data_in;
    logic [1:0]    owner;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] base [N];
    int         word_cnt [N];
    logic [N-1:0] last_gnt = '0;
    bit         chk_en = 1'b0;

    logic [N-1:0] gq[$];
    logic         bq[$];
    logic [7:0]   dq[$];

    // Reference state: burst in progress?, priority start, owner, words in this burst
    bit m_busy  = 1'b0;
    int m_next  = 0;
    int m_owner = 0;
    int m_used  = 0;

    fifo_push_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base[i] + 8'(word_cnt[i]);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (last_gnt[i]) word_cnt[i]++;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; fifo_full = 1'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) word_cnt[i] = 0;
        gq.delete(); bq.delete(); dq.delete();
    endtask

    // Every cycle: derive expected outputs from the reference, compare, log, advance reference
    always @(negedge clk) begin
        int g;
        logic [N-1:0] eg;
        logic [7:0]   ed;
        if (chk_en) begin
            g = -1;
            if (!rst && !fifo_full) begin
                if (!m_busy) begin
                    for (int k = 0; k < N; k++)
                        if (g < 0 && req[(m_next + k) % N]) g = (m_next + k) % N;
                end else if (req[m_owner]) begin
                    g = m_owner;
                end
            end
            eg = '0;
            ed = '0;
            if (g >= 0) begin
                eg[g] = 1'b1;
                ed = req_data[g*DW +: DW];
            end
            chk("gnt", 32'(gnt), 32'(eg));
            chk("fifo_push", 32'(fifo_push), 32'(g >= 0));
            chk("fifo_data_in", 32'(fifo_data_in), 32'(ed));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("busy", 32'(busy), 32'(m_busy));
            gq.push_back(gnt);
            bq.push_back(busy);
            if (fifo_push) dq.push_back(fifo_data_in);
            last_gnt = gnt;
            if (rst) begin
                m_busy = 0; m_next = 0; m_owner = 0; m_used = 0;
            end else if (!m_busy) begin
                if (g >= 0) begin
                    m_owner = g;
                    if (MB == 1) m_next = (g + 1) % N;
                    else begin m_busy = 1; m_used = 1; end
                end
            end else if (!req[m_owner]) begin
                m_busy = 0; m_next = (m_owner + 1) % N;
            end else if (g >= 0) begin
                m_used++;
                if (m_used == MB) begin m_busy = 0; m_next = (m_owner + 1) % N; end
            end
        end
    end

    initial begin
        logic [N-1:0] eg_q[$];
        logic         eb_q[$];
        logic [7:0]   ed_q[$];

        base[0] = 8'h00; base[1] = 8'h40; base[2] = 8'h20; base[3] = 8'hC0;
        for (int i = 0; i < N; i++) word_cnt[i] = 0;

        // Reset held two cycles with all producers requesting
        rst = 1'b1; req = 4'b1111; fifo_full = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_push", 32'(fifo_push), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        chk("post_rst_data", 32'(fifo_data_in), 32'h00);
        step();
        @(negedge clk);
        chk("post_rst_owner", 32'(owner), 32'h0);
        req = '0;
        step();

        // Single producer, six words with data advancing on each grant
        do_reset();
        req = 4'b0100;
        repeat (6) step();
        req = '0;
        step();
        eg_q = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        eb_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ed_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
        chk("single_len", 32'(dq.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk("single_gnt", 32'(gq[i]), 32'(eg_q[i]));
            chk("single_busy", 32'(bq[i]), 32'(eb_q[i]));
            chk("single_data", 32'(dq[i]), 32'(ed_q[i]));
        end

        // Full contention: four bursts of four, then wrap to producer 0
        do_reset();
        req = 4'b1111;
        repeat (17) step();
        req = '0;
        step();
        eg_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        for (int i = 0; i < 17; i++) chk("contention_gnt", 32'(gq[i]), 32'(eg_q[i]));

        // FIFO full stalls a burst after two pushes
        do_reset();
        req = 4'b0001;
        repeat (2) step();
        fifo_full = 1'b1;
        repeat (3) step();
        fifo_full = 1'b0;
        repeat (2) step();
        req = 4'b0011;
        step();
        req = '0;
        step();
        eg_q = '{4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        eb_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            chk("stall_gnt", 32'(gq[i]), 32'(eg_q[i]));
            chk("stall_busy", 32'(bq[i]), 32'(eb_q[i]));
        end

        // Early release: owner 0 drops after one word, one bubble, then producer 1
        do_reset();
        req = 4'b0011;
        step();
        req = 4'b0010;
        repeat (2) step();
        @(negedge clk);
        chk("release_owner", 32'(owner), 32'h1);
        req = '0;
        step();
        eg_q = '{4'b0001, 4'b0000, 4'b0010};
        for (int i = 0; i < 3; i++) chk("release_gnt", 32'(gq[i]), 32'(eg_q[i]));

        // Reset on the second cycle of producer 3's burst
        do_reset();
        req = 4'b1111;
        repeat (13) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        req = '0;
        step();
        chk("midrst_start", 32'(gq[12]), 32'b1000);
        chk("midrst_gnt", 32'(gq[13]), 32'b0000);
        chk("midrst_after", 32'(gq[14]), 32'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
Round-robin arbiter that shares the single write port (push/data_in/full) of the team's FIFO among N_REQ producers. It grants one producer at a time for a burst of up to MAX_BURST words, then rotates priority. It stalls on FIFO full, and releases early when the owner drops its request. It sits directly in front of the FIFO's write side, in the FIFO's write clock domain.

Parameters:
N_REQ, 4, number of requesting producers (2..16)
DW, 8, data word width; must match the FIFO data width
MAX_BURST, 4, maximum consecutive words granted to one owner before rotation (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-producer request; req[i] means producer i has a valid word on req_data slice i
req_data  in  N_REQ*DW  producer data; slice i is bits [i*DW +: DW]
gnt  out  N_REQ  one-hot accept strobe; gnt[i]=1 means producer i's word is pushed this cycle
fifo_full  in  1  FIFO full flag
fifo_push  out  1  FIFO push strobe
fifo_data_in  out  DW  FIFO write data
owner  out  clog2(N_REQ)  index of the current or last burst owner
busy  out  1  1 while in BURST state

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0. While rst=1, gnt and fifo_push are forced to 0 combinationally. busy=0.
- Grant path is combinational, with zero latency:
  - fifo_push = |gnt
  - fifo_data_in = req_data slice of the granted index
  - fifo_data_in = 0 when no grant
- gnt is never asserted when fifo_full=1 or rst=1. At most one gnt bit is set.
- Producer contract: hold req[i] and its data stable until gnt[i]. A word is consumed exactly on a cycle with gnt[i]=1.
- State IDLE:
  - sel = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - If any req and !fifo_full: gnt[sel]=1 and owner<=sel.
    - If MAX_BURST=1: rr_ptr<=sel+1 (mod N_REQ), stay IDLE.
    - Otherwise: burst_cnt<=1, go BURST.
  - If any req and fifo_full: no grant, stay IDLE, rr_ptr unchanged.
- State BURST (owner fixed):
  - req[owner]=1 and !fifo_full: gnt[owner]=1, burst_cnt++.
    - If burst_cnt+1==MAX_BURST: rr_ptr<=owner+1, go IDLE.
    - With no bubble: the next cycle IDLE may grant immediately.
  - req[owner]=1 and fifo_full: no grant; hold state, owner and burst_cnt.
  - req[owner]=0: no grant this cycle, rr_ptr<=owner+1, go IDLE. This costs one bubble cycle.
  - Requests from non-owners are ignored in BURST.
- rr_ptr wraps modulo N_REQ; owner+1 wraps from N_REQ-1 to 0.
- burst_cnt width is clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- Reset mid-burst: abort immediately. The burst is not resumed, and priority returns to producer 0.
- Fairness: with all producers requesting continuously and no full, each producer gets exactly MAX_BURST words per N_REQ*MAX_BURST cycles.

Test Plan:
- Reset, with N_REQ=4, MAX_BURST=4, DW=8: req=4'b1111, rst=1 for 2 cycles -> gnt=0, fifo_push=0, busy=0. First cycle after rst=0 -> gnt=4'b0001, owner=0.
- Single producer: req=4'b0100 held 6 cycles, data 0x20..0x25 advancing on each gnt, full=0 -> gnt[2] on 6 consecutive cycles; fifo_data_in=0x20..0x25; busy drops for the cycle after the 4th push, and no bubble.
- Full contention: req=4'b1111 for 17 cycles, full=0 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. That is 16 pushes in 16 cycles, then wrap to producer 0.
- Full stall mid-burst: req=4'b0001, full=1 after 2 pushes for 3 cycles -> gnt=0 and fifo_push=0 for 3 cycles, owner=0, busy=1. After full=0, 2 more pushes, then IDLE with rr_ptr=1.
- Early release: req[1] pending; owner 0 drops req after 1 push -> one cycle with no gnt, then gnt=4'b0010 (owner=1).
- Reset mid-burst: rst=1 on the 2nd cycle of a producer-3 burst, with all req=1 -> gnt=0 that cycle. After release, the grant goes to producer 0, not 3.
